wb_bcd_disp_master: RTL and testbench
=====================================

// Module: wb_bcd_disp_master
// PURPOSE
//  Wishbone master that sits directly upstream of the 7-segment display slave.
//  Accepts a binary value (0..9999) on a strobe and converts it to 4-digit packed BCD
//  with a sequential double-dabble (shift-add-3) engine. Then issues one 16-bit
//  Wishbone write to the display data register, so the display shows decimal.
//  A one-deep pending slot absorbs loads that arrive while busy.
// PARAMETERS
//  DISP_ADR   24'h000000  word address [24:1] of display data register
//  TMO_CYC    16          clocks to wait for ack/err before abandoning the write
//  OVF_CODE   16'hEEEE    data written when value > 9999
// PORTS
//  clk_i      in   1   system clock
//  nrst_i     in   1   asynchronous active-low reset
//  value_i    in   14  binary value to display
//  load_i     in   1   1-cycle strobe: capture value_i
//  busy_o     out  1   conversion or bus write in progress
//  done_o     out  1   1-cycle pulse: write acked
//  fail_o     out  1   1-cycle pulse: write got err or timed out
//  wb_adr_o   out  24  [24:1] address
//  wb_dat_o   out  16  write data
//  wb_dat_i   in   16  read data (unused)
//  wb_sel_o   out  2   byte selects
//  wb_we_o    out  1   write enable
//  wb_stb_o   out  1   strobe
//  wb_cyc_o   out  1   cycle
//  wb_ack_i   in   1   acknowledge
//  wb_err_i   in   1   error
// BEHAVIOUR
//  - Clock clk_i; reset nrst_i is asynchronous, active-low.
//  - Reset: all outputs 0, FSM=IDLE, pending slot empty, BCD shift reg 0.
//  - FSM states: IDLE, CONV, WRITE.
//    - IDLE: load_i (or pending valid) -> capture the value and go to CONV.
//      If the value > 9999, load OVF_CODE directly and go to WRITE.
//    - CONV: 14 iterations, 1/clk. Each clock: add 3 to every nibble >= 5, then shift
//      left 1 with the next binary MSB. After the 14th, go to WRITE.
//      Latency load_i -> first stb = 15 clk.
//    - WRITE: cyc=stb=we=1, sel=2'b11, adr=DISP_ADR, dat=BCD. Hold until ack/err/timeout.
//      ack -> done_o=1 for 1 clk. err or TMO_CYC clocks with no response -> fail_o=1.
//      No retry. cyc/stb drop on the clock after termination -> IDLE.
//  - busy_o=1 in CONV and WRITE. Also 1 in IDLE while the pending slot is valid.
//  - load_i while busy: value stored in the pending slot. A newer load overwrites it
//    (last wins). The pending value is serviced right after returning to IDLE.
//  - load_i in the same clock as termination: goes to the pending slot. Serviced next clk.
//  - ack and err in the same clock: treated as err (fail_o).
//  - wb outputs are registered and stable for the whole cycle. wb_dat_i is ignored.
//  - Reset mid-operation aborts immediately. cyc/stb drop asynchronously and the
//    pending slot is discarded.
// STRUCTURE
//  - Shared package/header: FSM state encodings; the nibble-correct constants 5 and 3;
//    the 9999 limit.
//  - One sub-module: bcd_dd_step. It is combinational: {bcd[15:0], bin_msb} ->
//    next bcd, doing the add-3 correction per nibble and then the shift.
//    Instantiated once and iterated by the FSM.
// TESTING
//  - load 1234, ack 2 clk after stb -> one write, dat=16'h1234, sel=11, adr=DISP_ADR; done_o once.
//  - load 0 and load 9999 -> dat 16'h0000 and 16'h9999; load 10000 -> 16'hEEEE, no CONV cycles.
//  - load 42 then load 77 and 815 while busy -> writes 16'h0042, then 16'h0815 only.
//  - ack held low -> stb drops after TMO_CYC clocks; fail_o pulses; next load still works.
//  - err=1 on first WRITE clk -> fail_o, no done_o; ack+err together -> fail_o.
//  - nrst_i low mid-CONV and mid-WRITE -> all outputs 0 at once; no write after release.

Source files
------------

// File: rtl/wb_bcd_disp_master_pkg.sv
// Shared types and constants for the BCD display master.
// Holds FSM encodings and the double-dabble nibble constants.
package wb_bcd_disp_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam logic [3:0]  NIB_CORR_MIN = 4'd5;
  localparam logic [3:0]  NIB_CORR_ADD = 4'd3;
  localparam logic [13:0] BCD_MAX      = 14'd9999;
  localparam int unsigned DD_ITERS     = 14;
  localparam logic [3:0]  DD_LAST      = 4'(DD_ITERS - 1);

  function automatic logic [3:0] nib_fix(input logic [3:0] n);
    return (n >= NIB_CORR_MIN) ? n + NIB_CORR_ADD : n;
  endfunction

endpackage

// File: rtl/wb_bcd_disp_master_bcd_dd_step.sv
// One double-dabble iteration: add-3 per nibble, then shift in MSB.
// Purely combinational; the FSM iterates it once per clock.
module bcd_dd_step
  import wb_bcd_disp_master_pkg::*;
(
  input  logic [15:0] bcd_i,
  input  logic        bin_msb_i,
  output logic [15:0] bcd_o,
  output logic        carry_o
);

  logic [15:0] fix;

  always_comb begin
    fix = '0;
    for (int i = 0; i < 4; i++) begin
      fix[i*4 +: 4] = nib_fix(bcd_i[i*4 +: 4]);
    end
    bcd_o   = {fix[14:0], bin_msb_i};
    carry_o = fix[15];
  end

endmodule

// File: rtl/wb_bcd_disp_master.sv
// Wishbone master: binary value -> packed BCD -> one display write.
// One-deep pending slot absorbs loads that arrive while busy.
module wb_bcd_disp_master
  import wb_bcd_disp_master_pkg::*;
#(
  parameter logic [23:0] DISP_ADR = 24'h000000,
  parameter int unsigned TMO_CYC  = 16,
  parameter logic [15:0] OVF_CODE = 16'hEEEE
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic [13:0] value_i,
  input  logic        load_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic [23:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic [1:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

  state_e      state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic        pend_v_q, pend_v_d;
  logic [13:0] pend_val_q, pend_val_d;
  logic        cyc_q, cyc_d;
  logic [15:0] dat_q, dat_d;
  logic [23:0] adr_q, adr_d;
  logic [1:0]  sel_q, sel_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;

  logic [13:0] src;
  logic        term;
  logic        tmo_hit;
  logic [15:0] step_bcd;
  logic        step_carry;
  logic        unused_ok;

  bcd_dd_step u_step (
    .bcd_i     (bcd_q),
    .bin_msb_i (bin_q[13]),
    .bcd_o     (step_bcd),
    .carry_o   (step_carry)
  );

  // Read data is never used; carry cannot fire for values <= 9999.
  assign unused_ok = ^{wb_dat_i, step_carry};

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    pend_v_d   = pend_v_q;
    pend_val_d = pend_val_q;
    cyc_d      = cyc_q;
    dat_d      = dat_q;
    adr_d      = adr_q;
    sel_d      = sel_q;
    done_d     = 1'b0;
    fail_d     = 1'b0;
    term       = 1'b0;
    tmo_hit    = (tmo_q == TMO_LAST);
    src        = load_i ? value_i : pend_val_q;

    if (state_q != ST_IDLE && load_i) begin
      pend_v_d   = 1'b1;
      pend_val_d = value_i;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (load_i || pend_v_q) begin
          pend_v_d = 1'b0;
          if (src > BCD_MAX) begin
            state_d = ST_WRITE;
            cyc_d   = 1'b1;
            dat_d   = OVF_CODE;
            adr_d   = DISP_ADR;
            sel_d   = 2'b11;
            tmo_d   = '0;
          end else begin
            state_d = ST_CONV;
            bin_d   = src;
            bcd_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      ST_CONV: begin
        bcd_d = step_bcd;
        bin_d = {bin_q[12:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == DD_LAST) begin
          state_d = ST_WRITE;
          cyc_d   = 1'b1;
          dat_d   = step_bcd;
          adr_d   = DISP_ADR;
          sel_d   = 2'b11;
          tmo_d   = '0;
        end
      end
      ST_WRITE: begin
        term   = wb_err_i | wb_ack_i | tmo_hit;
        fail_d = wb_err_i | (~wb_ack_i & tmo_hit);
        done_d = wb_ack_i & ~wb_err_i;
        tmo_d  = tmo_q + 16'd1;
        if (term) begin
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
          dat_d   = '0;
          adr_d   = '0;
          sel_d   = '0;
          tmo_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      pend_v_q   <= 1'b0;
      pend_val_q <= '0;
      cyc_q      <= 1'b0;
      dat_q      <= '0;
      adr_q      <= '0;
      sel_q      <= '0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      pend_v_q   <= pend_v_d;
      pend_val_q <= pend_val_d;
      cyc_q      <= cyc_d;
      dat_q      <= dat_d;
      adr_q      <= adr_d;
      sel_q      <= sel_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
    end
  end

  assign busy_o   = (state_q != ST_IDLE) | pend_v_q;
  assign done_o   = done_q;
  assign fail_o   = fail_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = cyc_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;

endmodule

// File: tb/tb_wb_bcd_disp_master.sv
// Bench for wb_bcd_disp_master: vector table, random txns, corner sequences.
// Expected data comes from a decimal-digit model, not the shift engine.
module tb_wb_bcd_disp_master;

  localparam logic [23:0] ADR = 24'h00A5C3;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [13:0] value_i = '0;
  logic        load_i = 1'b0;
  logic        busy_o, done_o, fail_o;
  logic [23:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i = 16'hDEAD;
  logic [1:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;

  int n_pass = 0;
  int n_chk  = 0;

  wb_bcd_disp_master #(
    .DISP_ADR (ADR),
    .TMO_CYC  (TMO),
    .OVF_CODE (16'hEEEE)
  ) dut (
    .clk_i    (clk),
    .nrst_i   (nrst),
    .value_i  (value_i),
    .load_i   (load_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .fail_o   (fail_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_stb_o (wb_stb_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i)
  );

  always #5 clk = ~clk;

  // kind: 0 ack, 1 err, 2 ack+err, 3 no response
  typedef struct {
    int          v;
    int          kind;
    int          dly;
    logic [15:0] dat;
    int          lat;
    int          stb;
    bit          done;
    bit          fail;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    if (v > 9999) return 16'hEEEE;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic wait_stb(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      load_i = 1'b0;
      if (wb_stb_o) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic txn(input int v, input int kind, input int dly,
                     input logic [15:0] edat, input int elat,
                     input int estb, input bit edone, input bit efail);
    int lat, stbc, nd, nf, late_stb;
    bit seen, stable;
    logic [15:0] dat;
    @(posedge clk); #1;
    value_i = 14'(v);
    load_i  = 1'b1;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      load_i = 1'b0;
      lat++;
      if (wb_stb_o) seen = 1'b1;
    end
    chk("stb_seen", 32'(seen), 32'd1);
    if (!seen) return;
    chk("latency", lat, elat);
    chk("dat", wb_dat_o, edat);
    chk("adr", wb_adr_o, ADR);
    chk("sel", wb_sel_o, 2'b11);
    chk("we_cyc", {wb_we_o, wb_cyc_o}, 2'b11);
    dat = wb_dat_o;
    stable = 1'b1;
    stbc = 0;
    nd = 0;
    nf = 0;
    for (int i = 0; i < 40; i++) begin
      if (!wb_stb_o) break;
      stbc++;
      if (wb_dat_o !== dat) stable = 1'b0;
      if (i == dly && kind != 3) begin
        wb_ack_i = (kind == 0 || kind == 2);
        wb_err_i = (kind == 1 || kind == 2);
      end
      @(posedge clk); #1;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      nd += int'(done_o);
      nf += int'(fail_o);
    end
    late_stb = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      nd += int'(done_o);
      nf += int'(fail_o);
      late_stb += int'(wb_stb_o);
    end
    chk("dat_stable", 32'(stable), 32'd1);
    chk("stb_cycles", stbc, estb);
    chk("done_cnt", nd, int'(edone));
    chk("fail_cnt", nf, int'(efail));
    chk("idle_after", {late_stb[7:0], 7'd0, busy_o}, 16'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {busy_o, done_o, fail_o, wb_stb_o, wb_cyc_o, wb_we_o,
              wb_sel_o, wb_dat_o, 8'(wb_adr_o != 0)}, 32'd0);
  endtask

  task automatic quiet(input string tag);
    int s = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      s += int'(wb_stb_o) + int'(busy_o);
    end
    chk(tag, s, 0);
  endtask

  initial begin
    bit seen;
    int v, kind, dly;

    vt[0] = '{1234,  0, 2, 16'h1234, 15, 3,   1, 0};
    vt[1] = '{0,     0, 0, 16'h0000, 15, 1,   1, 0};
    vt[2] = '{9999,  0, 1, 16'h9999, 15, 2,   1, 0};
    vt[3] = '{10000, 0, 0, 16'hEEEE, 1,  1,   1, 0};
    vt[4] = '{16383, 0, 3, 16'hEEEE, 1,  4,   1, 0};
    vt[5] = '{5,     1, 0, 16'h0005, 15, 1,   0, 1};
    vt[6] = '{678,   2, 1, 16'h0678, 15, 2,   0, 1};
    vt[7] = '{4321,  3, 0, 16'h4321, 15, TMO, 0, 1};
    vt[8] = '{1000,  0, 0, 16'h1000, 15, 1,   1, 0};
    vt[9] = '{8059,  0, 4, 16'h8059, 15, 5,   1, 0};

    repeat (3) @(posedge clk);
    #1 chk_zero("reset_state");
    nrst = 1'b1;

    foreach (vt[i])
      txn(vt[i].v, vt[i].kind, vt[i].dly, vt[i].dat, vt[i].lat,
          vt[i].stb, vt[i].done, vt[i].fail);

    for (int i = 0; i < 30; i++) begin
      v    = int'($urandom_range(0, 12000));
      kind = int'($urandom_range(0, 9));
      kind = (kind < 6) ? 0 : kind - 6;
      dly  = int'($urandom_range(0, 5));
      txn(v, kind, dly, ref_bcd(v), (v > 9999) ? 1 : 15,
          (kind == 3) ? TMO : dly + 1, kind == 0, kind != 0);
    end

    // Pending slot: 77 is overwritten by 815 before service.
    @(posedge clk); #1;
    value_i = 14'd42; load_i = 1'b1;
    @(posedge clk); #1 load_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 value_i = 14'd77; load_i = 1'b1;
    @(posedge clk); #1 load_i = 1'b0;
    @(posedge clk); #1 value_i = 14'd815; load_i = 1'b1;
    @(posedge clk); #1 load_i = 1'b0;
    chk("pend_busy", 32'(busy_o), 32'd1);
    wait_stb(seen);
    chk("pend_w1_seen", 32'(seen), 32'd1);
    chk("pend_w1_dat", wb_dat_o, 16'h0042);
    wb_ack_i = 1'b1;
    @(posedge clk); #1 wb_ack_i = 1'b0;
    chk("pend_w1_done", {done_o, busy_o, wb_stb_o}, 3'b110);
    wait_stb(seen);
    chk("pend_w2_seen", 32'(seen), 32'd1);
    chk("pend_w2_dat", wb_dat_o, 16'h0815);
    wb_ack_i = 1'b1;
    @(posedge clk); #1 wb_ack_i = 1'b0;
    chk("pend_w2_done", {done_o, busy_o, wb_stb_o}, 3'b100);
    quiet("pend_no_third");

    // Load in the same clock as the ack.
    @(posedge clk); #1;
    value_i = 14'd42; load_i = 1'b1;
    wait_stb(seen);
    chk("term_w1_seen", 32'(seen), 32'd1);
    wb_ack_i = 1'b1; value_i = 14'd300; load_i = 1'b1;
    @(posedge clk); #1 wb_ack_i = 1'b0; load_i = 1'b0;
    chk("term_w1_done", {done_o, busy_o, wb_stb_o}, 3'b110);
    wait_stb(seen);
    chk("term_w2_dat", wb_dat_o, 16'h0300);
    wb_ack_i = 1'b1;
    @(posedge clk); #1 wb_ack_i = 1'b0;
    chk("term_w2_done", 32'(done_o), 32'd1);
    quiet("term_quiet");

    // Reset mid-CONV with a pending value queued.
    @(posedge clk); #1;
    value_i = 14'd1234; load_i = 1'b1;
    @(posedge clk); #1 load_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 value_i = 14'd55; load_i = 1'b1;
    @(posedge clk); #1 load_i = 1'b0;
    #2 nrst = 1'b0;
    #1 chk_zero("rst_conv_zero");
    @(posedge clk); #1 nrst = 1'b1;
    quiet("rst_conv_quiet");

    // Reset mid-WRITE with no response.
    @(posedge clk); #1;
    value_i = 14'd9999; load_i = 1'b1;
    wait_stb(seen);
    chk("rst_wr_seen", 32'(seen), 32'd1);
    @(posedge clk); #2 nrst = 1'b0;
    #1 chk_zero("rst_wr_zero");
    @(posedge clk); #1 nrst = 1'b1;
    quiet("rst_wr_quiet");

    txn(2024, 0, 1, 16'h2024, 15, 2, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
